// File: rtl/pc_fetch.sv
// pc_fetch: PC register and single-outstanding instruction fetch sequencer.
// Optional PC_FETCH_MISALIGN_CHECK_EN faults misaligned PCs without a request.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module pc_fetch #(
  parameter int unsigned     XLEN     = `CPU_WIDTH,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] curr_pc,
  output logic            pc_ena,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic            inst_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   misalign;

`ifdef PC_FETCH_MISALIGN_CHECK_EN
  assign misalign = |curr_pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign imem_req_addr = curr_pc;

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    pc_ena         = 1'b0;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (misalign) begin
          state_nxt = HOLD;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) state_nxt = HOLD;
      end
      HOLD: begin
        inst_valid = 1'b1;
        pc_ena     = inst_ready;
        if (inst_ready) state_nxt = REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      curr_pc  <= RESET_PC;
      inst     <= '0;
      inst_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pc_ena) curr_pc <= next_pc;
      if (state == WAIT && imem_resp_valid) begin
        inst     <= imem_resp_data;
        inst_err <= imem_resp_err;
      end
      // a misaligned PC becomes a faulting null word without touching memory
      if (state == REQ && misalign) begin
        inst     <= '0;
        inst_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed and randomized checks of pc_fetch.
// Reference model tracks fetch/consume counts and the architectural PC.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic [31:0] curr_pc;
  logic        pc_ena;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_err;

  int checks = 0;
  int errors = 0;

  bit          pend, spur, resp_fired, err_hash;
  int          cnt, lat_max, rdy_mode, dec_mode, npc_mode;
  logic [31:0] paddr, err_addr, model_pc, r;

  pc_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .next_pc(next_pc),
    .curr_pc(curr_pc),
    .pc_ena(pc_ena),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_err(inst_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2], 16'h0013};
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == err_addr) || (err_hash && a[4:2] == 3'b101);
  endfunction

  // Environment: memory responder, decode ready and next-PC source.
  task automatic drive();
    resp_fired      = 0;
    imem_resp_valid = spur;
    imem_resp_data  = spur ? 32'hDEAD_BEEF : 32'h0;
    imem_resp_err   = spur;
    if (rst) begin
      pend = 0;
    end else if (pend) begin
      if (cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(paddr);
        imem_resp_err   = mem_err(paddr);
        pend            = 0;
        resp_fired      = 1;
      end else begin
        cnt--;
      end
    end
    case (rdy_mode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = 1'($urandom_range(0, 1));
      default: imem_req_ready = 1'b0;
    endcase
    case (dec_mode)
      0:       inst_ready = 1'b1;
      1:       inst_ready = 1'($urandom_range(0, 1));
      default: inst_ready = 1'b0;
    endcase
    if (npc_mode != 0) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    next_pc = model_pc + 32'd4;
        2:       next_pc = {r[31:2], 2'b00};
        default: next_pc = 32'hFFFF_FFFC;
      endcase
    end
    if (!rst && imem_req_valid && imem_req_ready) begin
      pend  = 1;
      paddr = imem_req_addr;
      cnt   = int'($urandom_range(0, lat_max - 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    spur = 0; pend = 0; err_hash = 0; err_addr = 32'h1;
    rdy_mode = 0; dec_mode = 0; lat_max = 1; npc_mode = 0;
    next_pc = 32'h8000_0004;
    drive();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (curr_pc !== 32'h8000_0000) begin
      errors++; $display("FAIL reset_pc: got %h exp 80000000", curr_pc);
    end
    checks++;
    if ({imem_req_valid, inst_valid, pc_ena, inst_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b exp 0000",
               {imem_req_valid, inst_valid, pc_ena, inst_err});
    end
    checks++;
    if (inst !== 32'h0) begin
      errors++; $display("FAIL reset_inst: got %h exp 0", inst);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL basic_c0_req: got %b exp 0", imem_req_valid);
    end
    drive(); @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL basic_c1_req: got %b/%h exp 1/80000000",
               imem_req_valid, imem_req_addr);
    end
    drive(); @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_c2_wait: got %b%b exp 00", imem_req_valid, inst_valid);
    end
    drive(); @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || pc_ena !== 1'b1 || inst !== 32'h0000_0013) begin
      errors++;
      $display("FAIL basic_c3_hold: got %b%b/%h exp 11/00000013",
               inst_valid, pc_ena, inst);
    end
    drive(); @(negedge clk);
    checks++;
    if (curr_pc !== 32'h8000_0004 || imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_c4_pc: got %h/%b exp 80000004/1",
               curr_pc, imem_req_valid);
    end
  endtask

  task automatic test_req_stall();
    rdy_mode = 2; spur = 1;
    repeat (4) begin
      drive(); @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 ||
          inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_req: got %b/%h/%b exp 1/80000004/0",
                 imem_req_valid, imem_req_addr, inst_valid);
      end
      checks++;
      if (inst !== 32'h0000_0013 || inst_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_spur: got %h/%b exp 00000013/0", inst, inst_err);
      end
    end
    spur = 0; rdy_mode = 0;
    drive(); @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_wait: got %b%b exp 00", imem_req_valid, inst_valid);
    end
    dec_mode = 2;
    drive(); @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || pc_ena !== 1'b0 || inst !== 32'h0001_0013) begin
      errors++;
      $display("FAIL stall_hold: got %b%b/%h exp 10/00010013",
               inst_valid, pc_ena, inst);
    end
  endtask

  task automatic test_hold_stall();
    next_pc = 32'h8000_0010;
    repeat (5) begin
      drive(); @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || pc_ena !== 1'b0 ||
          curr_pc !== 32'h8000_0004 || inst !== 32'h0001_0013) begin
        errors++;
        $display("FAIL hold_stable: got %b%b/%h/%h exp 10/80000004/00010013",
                 inst_valid, pc_ena, curr_pc, inst);
      end
    end
    dec_mode = 0;
    drive(); #1;
    checks++;
    if (pc_ena !== 1'b1) begin
      errors++; $display("FAIL hold_rise_ena: got %b exp 1", pc_ena);
    end
    @(negedge clk);
    checks++;
    if (curr_pc !== 32'h8000_0010 || imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_adv: got %h/%b exp 80000010/1", curr_pc, imem_req_valid);
    end
  endtask

  task automatic test_err();
    err_addr = 32'h8000_0010;
    next_pc  = 32'h8000_0014;
    drive(); @(negedge clk);
    drive(); @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_err !== 1'b1 || inst !== 32'h0004_0013) begin
      errors++;
      $display("FAIL err_hold: got %b%b/%h exp 11/00040013",
               inst_valid, inst_err, inst);
    end
    drive(); @(negedge clk);
    checks++;
    if (curr_pc !== 32'h8000_0014) begin
      errors++; $display("FAIL err_adv: got %h exp 80000014", curr_pc);
    end
    drive(); @(negedge clk);
    drive(); @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_err !== 1'b0 || inst !== 32'h0005_0013) begin
      errors++;
      $display("FAIL err_clear: got %b%b/%h exp 10/00050013",
               inst_valid, inst_err, inst);
    end
  endtask

  task automatic test_reset_wait();
    next_pc = 32'h8000_0020;
    drive(); @(negedge clk);
    drive(); @(negedge clk);
    checks++;
    if (curr_pc !== 32'h8000_0020 || imem_req_valid !== 1'b0 ||
        inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstw_wait: got %h/%b%b exp 80000020/00",
               curr_pc, imem_req_valid, inst_valid);
    end
    #2;
    rst = 1'b1; spur = 1;
    #1;
    checks++;
    if (curr_pc !== 32'h8000_0000 || {imem_req_valid, inst_valid, pc_ena} !== 3'b0) begin
      errors++;
      $display("FAIL rstw_async: got %h/%b exp 80000000/000",
               curr_pc, {imem_req_valid, inst_valid, pc_ena});
    end
    repeat (2) begin
      drive(); @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_err !== 1'b0) begin
        errors++;
        $display("FAIL rstw_spur: got %b/%h/%b exp 0/00000000/0",
                 inst_valid, inst, inst_err);
      end
    end
    rst = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rstw_idle: got %b exp 0", imem_req_valid);
    end
    spur = 0;
    drive(); @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || pend) begin
      errors++;
      $display("FAIL rstw_first: got %b/%h pend=%b exp 1/80000000 pend=0",
               imem_req_valid, imem_req_addr, pend);
    end
  endtask

  task automatic test_misalign();
    next_pc = 32'h8000_0006;
    drive(); @(negedge clk);
    drive(); @(negedge clk);
    drive(); @(negedge clk);
    checks++;
    if (curr_pc !== 32'h8000_0006) begin
      errors++; $display("FAIL mis_pc: got %h exp 80000006", curr_pc);
    end
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL mis_noreq: got %b exp 0", imem_req_valid);
    end
    next_pc = 32'h8000_0008;
    drive(); @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_err !== 1'b1 || inst !== 32'h0 || pend) begin
      errors++;
      $display("FAIL mis_hold: got %b%b/%h pend=%b exp 11/00000000 pend=0",
               inst_valid, inst_err, inst, pend);
    end
    drive(); @(negedge clk);
    checks++;
    if (curr_pc !== 32'h8000_0008 || imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL mis_adv: got %h/%b exp 80000008/1", curr_pc, imem_req_valid);
    end
`else
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0006) begin
      errors++;
      $display("FAIL mis_req: got %b/%h exp 1/80000006",
               imem_req_valid, imem_req_addr);
    end
`endif
  endtask

  task automatic test_random();
    int  n_acc, n_resp, n_cons;
    bit  started, exp_req, exp_v;
    lat_max = 3; rdy_mode = 1; dec_mode = 1; npc_mode = 1;
    err_hash = 1; err_addr = 32'h1;
    model_pc = 32'h8000_0000;
    do_reset();
    n_acc = 0; n_resp = 0; n_cons = 0; started = 0;
    for (int c = 0; c < 600; c++) begin
      exp_req = started && (n_acc == n_cons);
      exp_v   = (n_resp > n_cons);
      checks++;
      if (curr_pc !== model_pc) begin
        errors++; $display("FAIL rnd_pc c=%0d: got %h exp %h", c, curr_pc, model_pc);
      end
      checks++;
      if (imem_req_valid !== exp_req || inst_valid !== exp_v) begin
        errors++;
        $display("FAIL rnd_ctl c=%0d: got req=%b iv=%b exp req=%b iv=%b",
                 c, imem_req_valid, inst_valid, exp_req, exp_v);
      end
      checks++;
      if (pc_ena !== (exp_v && inst_ready)) begin
        errors++;
        $display("FAIL rnd_ena c=%0d: got %b exp %b", c, pc_ena, exp_v && inst_ready);
      end
      if (exp_req) begin
        checks++;
        if (imem_req_addr !== model_pc) begin
          errors++;
          $display("FAIL rnd_addr c=%0d: got %h exp %h", c, imem_req_addr, model_pc);
        end
      end
      if (exp_v) begin
        checks++;
        if (inst !== mem_word(model_pc) || inst_err !== mem_err(model_pc)) begin
          errors++;
          $display("FAIL rnd_inst c=%0d: got %h/%b exp %h/%b", c, inst, inst_err,
                   mem_word(model_pc), mem_err(model_pc));
        end
      end
      started = 1;
      drive();
      if (exp_req && imem_req_ready) n_acc++;
      if (resp_fired) n_resp++;
      if (exp_v && inst_ready) begin
        n_cons++;
        model_pc = next_pc;
      end
      @(negedge clk);
    end
    checks++;
    if (n_cons < 20) begin
      errors++; $display("FAIL rnd_progress: got %0d exp >=20", n_cons);
    end
  endtask

  initial begin
    rst = 1'b1;
    next_pc = 32'h0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    imem_resp_err = 1'b0;
    inst_ready = 1'b0;
    model_pc = 32'h8000_0000;
    test_reset();
    test_basic();
    test_req_stall();
    test_hold_stall();
    test_err();
    test_reset_wait();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- PC register and instruction-fetch sequencer for the npc core.
- Sits directly upstream of the next-PC mux:
  - presents `curr_pc` to it;
  - drives its `ena`;
  - registers its `next_pc` result.
- Issues one instruction-memory request per instruction over a valid/ready handshake and buffers the returned word.
- Hands the word to decode with a valid/ready handshake.
- At most one fetch is outstanding.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, `CPU_WIDTH (32), address/data width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- next_pc  in  XLEN  next PC from the next-PC mux.
- curr_pc  out  XLEN  registered PC, fed to the next-PC mux and to decode.
- pc_ena  out  1  advance strobe to the next-PC mux `ena` (combinational).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= curr_pc).
- imem_resp_valid  in  1  response word valid.
- imem_resp_data  in  XLEN  instruction word.
- imem_resp_err  in  1  access fault for this response.
- inst_valid  out  1  instruction buffer holds a word for decode.
- inst_ready  in  1  decode consumes the word.
- inst  out  XLEN  buffered instruction.
- inst_err  out  1  buffered word carries a fetch fault (or misalign, see below).

Behaviour:
- Reset values, applied asynchronously while rst=1:
  - curr_pc=RESET_PC, state=IDLE, inst=0, inst_err=0.
  - imem_req_valid=0, inst_valid=0, pc_ena=0.
- State machine, 2-bit encoding: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - No outputs asserted.
  - Unconditionally moves to REQ on the next edge, so the first request appears the cycle after reset release.
- REQ:
  - imem_req_valid=1, imem_req_addr=curr_pc.
  - imem_req_ready=1 → WAIT.
  - Otherwise remain in REQ with address stable.
  - valid never drops before ready.
- WAIT:
  - imem_resp_valid=1 → capture data and err into inst/inst_err, go to HOLD.
  - A response in the same cycle as the request handshake is illegal. Memory latency is ≥1 cycle after acceptance.
- HOLD:
  - inst_valid=1, inst and inst_err stable.
  - pc_ena = inst_valid & inst_ready.
  - When pc_ena=1: curr_pc<=next_pc, go to REQ.
- pc_ena is 0 in every state other than HOLD, so the next-PC mux holds curr_pc.
- Fetch-to-decode latency:
  - Minimum 3 cycles from entry to REQ: REQ → WAIT → resp → HOLD.
  - Throughput is one instruction per 3 cycles with zero-wait memory and decode always ready.
- inst_err=1 does not change sequencing. Decode is responsible for trapping; pc_fetch still advances on handshake.
- imem_resp_valid outside WAIT is ignored; no state change.
- Reset mid-operation (REQ/WAIT/HOLD) returns to IDLE with curr_pc=RESET_PC. The memory is reset by the same rst, so no stale response is expected.
- PC arithmetic is performed in the next-PC mux; pc_fetch only registers next_pc. 32-bit wrap (32'hFFFF_FFFC → 0) is passed through unchanged.

Optional Feature:
- Macro: PC_FETCH_MISALIGN_CHECK_EN.
- Defined:
  - In REQ, if curr_pc[1:0]!=2'b00, no request is issued (imem_req_valid=0).
  - The FSM goes directly to HOLD with inst=32'h0000_0000 and inst_err=1.
  - Advance rules are otherwise unchanged.
- Undefined:
  - No check; low PC bits are forwarded on imem_req_addr as-is.

Test Plan:
- Reset release, memory ready=1, 1-cycle response 32'h0000_0013, inst_ready=1:
  - req_addr=8000_0000 at cycle 1;
  - inst_valid at cycle 3 with pc_ena=1;
  - next_pc=8000_0004 appears on curr_pc at cycle 4.
- imem_req_ready held 0 for 4 cycles:
  - imem_req_valid and addr stay constant;
  - no WAIT entry until ready=1.
- inst_ready=0 for 5 cycles in HOLD:
  - inst and curr_pc stable, pc_ena=0;
  - advance occurs exactly on the cycle inst_ready rises.
- Response with imem_resp_err=1 at addr 8000_0010:
  - inst_err=1 in HOLD;
  - on handshake curr_pc loads next_pc and inst_err clears with the next response.
- Assert rst during WAIT:
  - immediate curr_pc=8000_0000, inst_valid=0, req_valid=0;
  - a spurious resp_valid during reset has no effect;
  - the first request after release is to 8000_0000.
- With PC_FETCH_MISALIGN_CHECK_EN, next_pc=8000_0006:
  - no request issued;
  - HOLD with inst_err=1, inst=0;
  - without the macro, req_addr=8000_0006 is issued.
